cic_decimator_cfg: RTL and testbench
====================================

Name: cic_decimator_cfg

Overview:
Parametrised N-stage cascaded integrator-comb (CIC) decimator with a decimation ratio selectable at run time. The ratio is R = 2^dec_sel, up to 2^LOG2R_MAX.
It sits directly after the delta-sigma modulator bitstream and replaces the fixed 64x decimator.
The output is gain-normalised: full scale at the output is the same for every selected ratio.
It adds a sample-enable input and an output-valid strobe.

Parameters:
IW, 2, signed input width. The modulator bit feeds in as {1'b0, bit}.
N, 4, number of integrator and comb stages (1..6). The differential delay M is fixed at 1.
LOG2R_MAX, 6, log2 of the maximum decimation ratio (64).
OW, IW+N*LOG2R_MAX (26), signed width of all internal registers and of the output.
SW, $clog2(LOG2R_MAX+1), width of dec_sel.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  input sample strobe; the block advances only on cycles with en=1
dec_sel  in  SW  log2 of the decimation ratio; values above LOG2R_MAX are clamped to LOG2R_MAX
in  in  IW  signed input sample, qualified by en
out  out  OW  signed decimated output, scaled by 2^(N*(LOG2R_MAX-dec_sel))
out_valid  out  1  one-cycle pulse when out updates
busy_ratio  out  SW  ratio currently in effect (the latched dec_sel)

Behaviour:
- Reset: one clock with rst=1 does the following.
  - Clears all integrators, comb delays, the phase counter, out and out_valid to 0.
  - Latches clamp(dec_sel) into busy_ratio.
  - Reset mid-operation discards all state; no out_valid is produced from pre-reset data.
  - Changes to dec_sel outside reset are ignored until the next rst.
- Arithmetic: all registers are OW bits, two's complement, wrap-around (modular). Never saturate.
  - Wrap in the integrators is expected and is cancelled by the combs.
  - The result is exact whenever the true value fits in OW bits.
- Integrators (update only when en=1):
  - I1 <= I1 + sext(in).
  - Ik <= Ik + I(k-1) for k = 2..N, using the pre-edge value of I(k-1) (pipelined).
  - When en=0, all state holds and no cycle is counted.
- Phase counter:
  - Counts en cycles from 0 to R-1 and wraps to 0, with R = 2^busy_ratio.
  - Decimation event: en=1 and count == R-1.
  - With R=1 every en cycle is an event.
- Comb section (evaluated in the event cycle):
  - C0 = pre-edge IN.
  - Ck = C(k-1) - Dk for k = 1..N.
  - At the event edge, Dk <= C(k-1) and out <= CN << (N*(LOG2R_MAX-busy_ratio)).
  - out_valid = 1 in the cycle after the event, otherwise 0.
  - out holds between events.
- Gain: DC gain is R^N before the shift, so it is 2^(N*LOG2R_MAX) for every ratio.
  - A constant input x settles at out = x*2^(N*LOG2R_MAX).
  - Settling completes by the (N+2)th out_valid after the input becomes constant.
- Cadence: out_valid pulses are exactly R en-cycles apart, independent of gaps in en.
- Simultaneous rst and en: rst wins and the sample is dropped.

Test Plan:
- Reset check: hold rst 5 cycles, then release with dec_sel=6.
  - out=0 and out_valid=0 throughout.
  - busy_ratio=6.
  - No out_valid before 64 en cycles.
- DC full scale: in=1 constant, en=1, dec_sel=6.
  - out_valid every 64 cycles.
  - out = 16777216 from the 6th valid onward.
  - No intermediate value exceeds the OW range.
- Ratio normalisation: same stimulus with dec_sel=3.
  - out_valid every 8 cycles.
  - Steady out = 4096<<12 = 16777216.
  - Repeat with dec_sel=0: out = 16777216 on every en cycle after settling.
  - Repeat with dec_sel=7: clamped to 6; busy_ratio=6.
- Negative full scale and wrap: in=-2 constant, dec_sel=6.
  - Steady out = -33554432.
  - Integrators wrap many times while out stays exact.
- Enable gaps: random en duty 30% with in=1, dec_sel=4.
  - Pulses occur every 16 en-high cycles.
  - Steady out = 16777216.
  - State is unchanged across en=0 stretches.
- Bitstream and reset mid-run:
  - Drive a second-order modulator bitstream ({1'b0,bit}) through the block and compare out bit-exactly against a software CIC model (N=4, R=64, M=1).
  - Assert rst mid-frame: out and out_valid clear next cycle, and the model realigns from zero state.

Source files
------------

// File: rtl/cic_decimator_cfg.sv
// N-stage CIC decimator with run-time ratio R = 2^dec_sel (latched at reset) and
// output gain normalised so full scale is identical for every ratio.
module cic_decimator_cfg #(
  parameter int unsigned IW        = 2,
  parameter int unsigned N         = 4,
  parameter int unsigned LOG2R_MAX = 6,
  parameter int unsigned OW        = IW + N * LOG2R_MAX,
  parameter int unsigned SW        = $clog2(LOG2R_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SW-1:0]        dec_sel,
  input  logic signed [IW-1:0] in,
  output logic signed [OW-1:0] out,
  output logic                 out_valid,
  output logic [SW-1:0]        busy_ratio
);

  localparam int unsigned CW  = LOG2R_MAX;
  localparam int unsigned SHW = $clog2(N * LOG2R_MAX + 1);

  logic signed [OW-1:0] integ_q [N];
  logic signed [OW-1:0] integ_d [N];
  logic signed [OW-1:0] dly_q   [N];
  logic signed [OW-1:0] comb_c  [N+1];
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [CW-1:0]        phase_mask_c;
  logic [SW-1:0]        busy_q;
  logic [SW-1:0]        sel_clamped_c;
  logic [SHW-1:0]       shamt_c;
  logic signed [OW-1:0] out_q;
  logic                 valid_q;
  logic                 event_c;

  assign sel_clamped_c = (dec_sel > SW'(LOG2R_MAX)) ? SW'(LOG2R_MAX) : dec_sel;
  assign phase_mask_c  = CW'((32'd1 << busy_q) - 32'd1);
  assign event_c       = en && (cnt_q == phase_mask_c);
  assign cnt_d         = event_c ? '0 : cnt_q + CW'(1);
  // Normalising shift restores the gain lost by running a smaller ratio.
  assign shamt_c       = SHW'(N) * (SHW'(LOG2R_MAX) - SHW'(busy_q));

  // Pipelined integrators: each stage accumulates the previous stage's pre-edge value.
  always_comb begin
    integ_d[0] = integ_q[0] + {{(OW-IW){in[IW-1]}}, in};
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // Comb chain evaluated on the last integrator output, committed on the event edge.
  always_comb begin
    comb_c[0] = integ_q[N-1];
    for (int k = 1; k <= N; k++) begin
      comb_c[k] = comb_c[k-1] - dly_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= sel_clamped_c;
    end else begin
      valid_q <= event_c;
      if (en) begin
        integ_q <= integ_d;
        cnt_q   <= cnt_d;
      end
      if (event_c) begin
        for (int k = 0; k < N; k++) begin
          dly_q[k] <= comb_c[k];
        end
        out_q <= comb_c[N] << shamt_c;
      end
    end
  end

  assign out        = out_q;
  assign out_valid  = valid_q;
  assign busy_ratio = busy_q;

endmodule

// File: tb/tb_cic_decimator_cfg.sv
// Directed bench for cic_decimator_cfg: DC/ratio vectors from a table, plus reset,
// enable-gap and modulator-bitstream sequences checked against a boxcar^4 convolution.
module tb_cic_decimator_cfg;

  localparam int IW = 2;
  localparam int N  = 4;
  localparam int LM = 6;
  localparam int OW = IW + N * LM;
  localparam int SW = 3;
  localparam int HL = N * 63 + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic [SW-1:0]        dec_sel = 3'd6;
  logic signed [IW-1:0] in_s = '0;
  logic signed [OW-1:0] out_s;
  logic                 out_valid;
  logic [SW-1:0]        busy_ratio;

  cic_decimator_cfg #(.IW(IW), .N(N), .LOG2R_MAX(LM)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dec_sel   (dec_sel),
    .in        (in_s),
    .out       (out_s),
    .out_valid (out_valid),
    .busy_ratio(busy_ratio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0]        sel;
    logic signed [IW-1:0] din;
    int                   duty;
    int                   exp_ratio;
    int                   exp_period;
    longint               exp_out;
  } vec_t;

  vec_t   vecs [6];
  int     n_chk = 0;
  int     n_fail = 0;
  longint h  [HL];
  longint ht [HL];
  int     xs [4096];

  task automatic check(input string nm, input longint act, input longint exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic signed [IW-1:0] d);
    rst = r; en = e; in_s = d;
    @(posedge clk);
    #1;
  endtask

  // Run one table vector: reset with its dec_sel, then collect 8 output pulses.
  task automatic run_vec(input int id, input vec_t v);
    int     ncnt, nval, last, cyc;
    logic   e;
    longint prev;
    string  tag;
    tag = $sformatf("vec%0d", id);
    dec_sel = v.sel;
    step(1'b1, 1'b1, v.din);
    step(1'b1, 1'b0, v.din);
    check({tag, " out after reset"}, out_s, 0);
    check({tag, " busy_ratio"}, longint'(busy_ratio), v.exp_ratio);
    dec_sel = v.sel ^ 3'b101;
    ncnt = 0; nval = 0; last = 0; cyc = 0;
    while (nval < 8 && cyc < 4000) begin
      e    = ($urandom_range(0, 99) < v.duty);
      prev = out_s;
      step(1'b0, e, v.din);
      cyc++;
      if (e) ncnt++;
      if (!e) begin
        check({tag, " hold out"}, out_s, prev);
        check({tag, " no valid on gap"}, longint'(out_valid), 0);
      end
      if (out_valid) begin
        nval++;
        check({tag, " pulse spacing"}, ncnt - last, v.exp_period);
        last = ncnt;
        if (nval >= 6) check({tag, " steady out"}, out_s, v.exp_out);
      end
    end
    check({tag, " pulses seen"}, nval, 8);
    check({tag, " busy_ratio held"}, longint'(busy_ratio), v.exp_ratio);
  endtask

  function automatic longint model_out(input int t_ev);
    longint acc;
    acc = 0;
    for (int j = 0; j < HL; j++) begin
      if (t_ev - 4 - j >= 0) acc += h[j] * longint'(xs[t_ev - 4 - j]);
    end
    return acc;
  endfunction

  initial begin
    int     t, nv, b, q, e1, e2, vin;
    longint acc;
    logic   e;

    vecs[0] = '{3'd6,  2'sd1, 100, 6, 64, 64'sd16777216};
    vecs[1] = '{3'd3,  2'sd1, 100, 3,  8, 64'sd16777216};
    vecs[2] = '{3'd0,  2'sd1, 100, 0,  1, 64'sd16777216};
    vecs[3] = '{3'd7,  2'sd1, 100, 6, 64, 64'sd16777216};
    vecs[4] = '{3'd6, -2'sd2, 100, 6, 64, -64'sd33554432};
    vecs[5] = '{3'd4,  2'sd1,  30, 4, 16, 64'sd16777216};

    // Impulse response of four cascaded 64-tap boxcars.
    for (int j = 0; j < HL; j++) h[j] = (j < 64) ? 1 : 0;
    for (int s = 1; s < N; s++) begin
      for (int n = 0; n < HL; n++) begin
        acc = 0;
        for (int i = 0; i < 64; i++) if (n - i >= 0) acc += h[n - i];
        ht[n] = acc;
      end
      h = ht;
    end

    // Reset held 5 cycles with en=1: sample dropped, outputs stay clear.
    dec_sel = 3'd6;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'sd1);
      check("reset out", out_s, 0);
      check("reset valid", longint'(out_valid), 0);
    end
    check("reset busy_ratio", longint'(busy_ratio), 6);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Modulator bitstream vs. convolution model, with a reset mid-frame.
    dec_sel = 3'd6;
    step(1'b1, 1'b0, 2'sd0);
    t = 0; nv = 0; e1 = 0; e2 = 0;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      if (cyc == 1300) begin
        step(1'b1, 1'b1, 2'sd1);
        check("midrun reset out", out_s, 0);
        check("midrun reset valid", longint'(out_valid), 0);
        t = 0;
        continue;
      end
      e = ($urandom_range(0, 9) != 0);
      b = 0;
      if (e) begin
        vin = 300 - 2 * e1 + e2;
        q   = (vin >= 512) ? 1024 : 0;
        b   = (q != 0) ? 1 : 0;
        e2  = e1;
        e1  = q - vin;
        xs[t] = b;
      end
      step(1'b0, e, IW'(b));
      if (e) t++;
      if (out_valid) begin
        nv++;
        check("bitstream out", out_s, model_out(t - 1));
        check("bitstream phase", t % 64, 0);
      end
    end
    check("bitstream pulses", longint'(nv >= 30), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
